// File: rtl/neuron_argmax_classifier.sv
// Argmax output stage: captures all neuron scores in one cycle, then scans them one per cycle
// with a single signed comparator. Optional runner-up/margin outputs: NEURON_ARGMAX_RUNNER_UP_EN.
module neuron_argmax_classifier #(
  parameter int NUM_NEURONS = 10,
  parameter int SCORE_WIDTH = 26,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [NUM_NEURONS*SCORE_WIDTH-1:0] IN_SCORES,
  output logic                               busy,
  output logic                               done,
  output logic [INDEX_WIDTH-1:0]             CLASS,
`ifdef NEURON_ARGMAX_RUNNER_UP_EN
  output logic [INDEX_WIDTH-1:0]             SECOND_CLASS,
  output logic [SCORE_WIDTH:0]               MARGIN,
`endif
  output logic [SCORE_WIDTH-1:0]             MAX_SCORE
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] RESULT = 2'd2;

  localparam logic [INDEX_WIDTH-1:0] LAST_PTR = INDEX_WIDTH'(NUM_NEURONS - 1);

  // state_q is the observable FSM state for external checkers.
  logic [1:0]                         state_q, state_d;
  logic [NUM_NEURONS*SCORE_WIDTH-1:0] shadow_q, shadow_d;
  logic [INDEX_WIDTH-1:0]             ptr_q, ptr_d;
  logic signed [SCORE_WIDTH-1:0]      best_score_q, best_score_d;
  logic [INDEX_WIDTH-1:0]             best_idx_q, best_idx_d;
  logic [INDEX_WIDTH-1:0]             class_q, class_d;
  logic [SCORE_WIDTH-1:0]             max_q, max_d;
  logic signed [SCORE_WIDTH-1:0]      cur_score;
`ifdef NEURON_ARGMAX_RUNNER_UP_EN
  logic signed [SCORE_WIDTH-1:0]      second_score_q, second_score_d;
  logic [INDEX_WIDTH-1:0]             second_idx_q, second_idx_d;
  logic [INDEX_WIDTH-1:0]             second_class_q, second_class_d;
  logic [SCORE_WIDTH:0]               margin_q, margin_d;
`endif

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    ptr_d        = ptr_q;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    class_d      = class_q;
    max_d        = max_q;
    cur_score    = shadow_q[int'(ptr_q)*SCORE_WIDTH +: SCORE_WIDTH];
`ifdef NEURON_ARGMAX_RUNNER_UP_EN
    second_score_d = second_score_q;
    second_idx_d   = second_idx_q;
    second_class_d = second_class_q;
    margin_d       = margin_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d     = IN_SCORES;
          best_score_d = IN_SCORES[SCORE_WIDTH-1:0];
          best_idx_d   = '0;
          ptr_d        = INDEX_WIDTH'(1);
`ifdef NEURON_ARGMAX_RUNNER_UP_EN
          second_score_d = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
          second_idx_d   = '0;
`endif
          // A single neuron needs no scan; its score is the answer.
          if (NUM_NEURONS == 1) begin
            state_d = RESULT;
            class_d = '0;
            max_d   = IN_SCORES[SCORE_WIDTH-1:0];
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        // Strict comparison keeps the lower index on ties.
        if (cur_score > best_score_q) begin
          best_score_d = cur_score;
          best_idx_d   = ptr_q;
`ifdef NEURON_ARGMAX_RUNNER_UP_EN
          second_score_d = best_score_q;
          second_idx_d   = best_idx_q;
        end else if (cur_score > second_score_q) begin
          second_score_d = cur_score;
          second_idx_d   = ptr_q;
`endif
        end
        ptr_d = ptr_q + INDEX_WIDTH'(1);
        if (ptr_q == LAST_PTR) begin
          state_d = RESULT;
          class_d = best_idx_d;
          max_d   = best_score_d;
`ifdef NEURON_ARGMAX_RUNNER_UP_EN
          second_class_d = second_idx_d;
          // Best is never below second, so the one-bit-wider difference is non-negative.
          margin_d = {best_score_d[SCORE_WIDTH-1], best_score_d}
                   - {second_score_d[SCORE_WIDTH-1], second_score_d};
`endif
        end
      end
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      ptr_q        <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      class_q      <= '0;
      max_q        <= '0;
`ifdef NEURON_ARGMAX_RUNNER_UP_EN
      second_score_q <= '0;
      second_idx_q   <= '0;
      second_class_q <= '0;
      margin_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      ptr_q        <= ptr_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      class_q      <= class_d;
      max_q        <= max_d;
`ifdef NEURON_ARGMAX_RUNNER_UP_EN
      second_score_q <= second_score_d;
      second_idx_q   <= second_idx_d;
      second_class_q <= second_class_d;
      margin_q       <= margin_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == RESULT);
  assign CLASS     = class_q;
  assign MAX_SCORE = max_q;
`ifdef NEURON_ARGMAX_RUNNER_UP_EN
  assign SECOND_CLASS = second_class_q;
  assign MARGIN       = margin_q;
`endif

endmodule
